ctrl_pwm_gen: RTL and testbench

//  Synthesizable digital PWM source producing the 'ctrl' gate signal that drives

---
 rtl/ctrl_pwm_gen.sv | 166 ++++++++++++++++
 tb/tb_ctrl_pwm_gen.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/ctrl_pwm_gen.sv
// -----------------------------------------------------------------------------
// ctrl_pwm_gen
//   Digital PWM source for the 'ctrl' gate signal of current_switch. Period and
//   high-time are programmable through a valid/ready config port and are
//   double-buffered: an accepted setting is parked in a shadow register and is
//   only copied to the active register on a period boundary (or straight away
//   while idle), so ctrl never produces a runt or stretched pulse.
//
// Ports
//   emu_clk      in   clock, all state on rising edge
//   emu_rst_n    in   asynchronous active-low reset
//   en           in   run request (sampled in IDLE and at each period wrap)
//   cfg_valid    in   config offer
//   cfg_ready    out  shadow register free (no config pending)
//   cfg_period   in   requested period in cycles (clamped to >= 2)
//   cfg_high     in   requested high-time in cycles (clamped to <= period)
//   ctrl         out  registered PWM output
//   cycle_start  out  one-cycle pulse while cnt==0 in RUN
//   running      out  high while in RUN
// -----------------------------------------------------------------------------
module ctrl_pwm_gen #(
    parameter int CNT_W      = 16,
    parameter int DEF_PERIOD = 4,
    parameter int DEF_HIGH   = 2
) (
    input  logic             emu_clk,
    input  logic             emu_rst_n,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
    output logic             ctrl,
    output logic             cycle_start,
    output logic             running
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_q,      state_d;
    logic [CNT_W-1:0]   cnt_q,        cnt_d;
    logic [CNT_W-1:0]   act_per_q,    act_per_d;
    logic [CNT_W-1:0]   act_high_q,   act_high_d;
    logic [CNT_W-1:0]   pend_per_q,   pend_per_d;
    logic [CNT_W-1:0]   pend_high_q,  pend_high_d;
    logic               pend_valid_q, pend_valid_d;
    logic               ctrl_q,       ctrl_d;
    logic               cyc_start_q,  cyc_start_d;

    logic               accept;
    logic               wrap;
    logic               apply_now;
    logic [CNT_W-1:0]   clamp_per;
    logic [CNT_W-1:0]   clamp_high;
    logic [CNT_W-1:0]   eff_high;
    logic [CNT_W-1:0]   cnt_inc;

    // Clamp incoming config: period at least 2, high-time at most the period.
    always_comb begin
        clamp_per  = (cfg_period < CNT_W'(2)) ? CNT_W'(2) : cfg_period;
        clamp_high = (cfg_high > clamp_per) ? clamp_per : cfg_high;
    end

    always_comb begin
        accept    = cfg_valid && !pend_valid_q;
        wrap      = (cnt_q == (act_per_q - CNT_W'(1)));
        // The shadow moves to active immediately when idle, otherwise only on
        // the last cycle of a period. A config accepted in that same wrap
        // cycle only sets pend_valid_q for the following wrap.
        apply_now = pend_valid_q && ((state_q == ST_IDLE) || wrap);
        // The high-time that governs the next period's first cycle.
        eff_high  = apply_now ? pend_high_q : act_high_q;
        cnt_inc   = cnt_q + CNT_W'(1);
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        act_per_d    = act_per_q;
        act_high_d   = act_high_q;
        pend_per_d   = pend_per_q;
        pend_high_d  = pend_high_q;
        pend_valid_d = pend_valid_q;
        ctrl_d       = ctrl_q;
        cyc_start_d  = 1'b0;

        // apply_now needs pend_valid_q=1 while accept needs it 0, so at most
        // one of the two shadow updates happens per cycle.
        if (apply_now) begin
            act_per_d    = pend_per_q;
            act_high_d   = pend_high_q;
            pend_valid_d = 1'b0;
        end
        if (accept) begin
            pend_per_d   = clamp_per;
            pend_high_d  = clamp_high;
            pend_valid_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d  = '0;
                ctrl_d = 1'b0;
                if (en) begin
                    state_d     = ST_RUN;
                    cyc_start_d = 1'b1;
                    ctrl_d      = (eff_high != '0);
                end
            end
            ST_RUN: begin
                if (wrap) begin
                    cnt_d = '0;
                    if (en) begin
                        cyc_start_d = 1'b1;
                        ctrl_d      = (eff_high != '0);
                    end else begin
                        // Period has completed; stop cleanly with ctrl low.
                        state_d = ST_IDLE;
                        ctrl_d  = 1'b0;
                    end
                end else begin
                    cnt_d  = cnt_inc;
                    ctrl_d = (cnt_inc < act_high_q);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                ctrl_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge emu_clk or negedge emu_rst_n) begin
        if (!emu_rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            act_per_q    <= CNT_W'(DEF_PERIOD);
            act_high_q   <= CNT_W'(DEF_HIGH);
            pend_per_q   <= '0;
            pend_high_q  <= '0;
            pend_valid_q <= 1'b0;
            ctrl_q       <= 1'b0;
            cyc_start_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            act_per_q    <= act_per_d;
            act_high_q   <= act_high_d;
            pend_per_q   <= pend_per_d;
            pend_high_q  <= pend_high_d;
            pend_valid_q <= pend_valid_d;
            ctrl_q       <= ctrl_d;
            cyc_start_q  <= cyc_start_d;
        end
    end

    assign cfg_ready   = !pend_valid_q;
    assign ctrl        = ctrl_q;
    assign cycle_start = cyc_start_q;
    assign running     = (state_q == ST_RUN);

endmodule

// File: tb/tb_ctrl_pwm_gen.sv
// -----------------------------------------------------------------------------
// tb_ctrl_pwm_gen
//   Directed bench for ctrl_pwm_gen. Inputs are driven and outputs sampled on
//   the falling clock edge; each expected ctrl/cycle_start value comes from the
//   period, high-time and phase the bench expects the generator to be at.
// -----------------------------------------------------------------------------
module tb_ctrl_pwm_gen;

    localparam int CNT_W = 16;

    logic             emu_clk;
    logic             emu_rst_n;
    logic             en;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CNT_W-1:0] cfg_period;
    logic [CNT_W-1:0] cfg_high;
    logic             ctrl;
    logic             cycle_start;
    logic             running;

    int tests_run  = 0;
    int tests_fail = 0;

    ctrl_pwm_gen #(
        .CNT_W      (CNT_W),
        .DEF_PERIOD (4),
        .DEF_HIGH   (2)
    ) dut (
        .emu_clk     (emu_clk),
        .emu_rst_n   (emu_rst_n),
        .en          (en),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_period  (cfg_period),
        .cfg_high    (cfg_high),
        .ctrl        (ctrl),
        .cycle_start (cycle_start),
        .running     (running)
    );

    initial emu_clk = 1'b0;
    always #5 emu_clk = ~emu_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
        tests_run++;
        if (obs !== exp_val) begin
            tests_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp_val, $time);
        end
    endtask

    task automatic step();
        @(negedge emu_clk);
    endtask

    // Advance n cycles while in RUN; phase ph0+i of a (per, high) waveform is
    // expected on the i-th observation.
    task automatic expect_cycles(input int n, input int per, input int high, input int ph0);
        int ph;
        for (int i = 0; i < n; i++) begin
            step();
            ph = (ph0 + i) % per;
            $display("[TB] per=%0d high=%0d phase=%0d ctrl=%0b cycle_start=%0b",
                     per, high, ph, ctrl, cycle_start);
            check($sformatf("ctrl p%0d/h%0d ph%0d", per, high, ph), {31'd0, ctrl},
                  (ph < high) ? 32'd1 : 32'd0);
            check($sformatf("cycle_start p%0d ph%0d", per, ph), {31'd0, cycle_start},
                  (ph == 0) ? 32'd1 : 32'd0);
            check("running", {31'd0, running}, 32'd1);
        end
    endtask

    task automatic offer(input int per, input int high);
        cfg_valid  = 1'b1;
        cfg_period = CNT_W'(per);
        cfg_high   = CNT_W'(high);
    endtask

    initial begin
        emu_rst_n  = 1'b0;
        en         = 1'b0;
        cfg_valid  = 1'b0;
        cfg_period = '0;
        cfg_high   = '0;

        // Reset state
        step(); step(); step();
        check("rst ctrl",        {31'd0, ctrl},        32'd0);
        check("rst running",     {31'd0, running},     32'd0);
        check("rst cycle_start", {31'd0, cycle_start}, 32'd0);
        check("rst cfg_ready",   {31'd0, cfg_ready},   32'd1);

        // Defaults 4/2: first RUN cycle one clock after en is sampled
        emu_rst_n = 1'b1;
        en        = 1'b1;
        expect_cycles(8, 4, 2, 0);
        expect_cycles(1, 4, 2, 0);

        // Config (10,3) accepted mid-period; current 4/2 period completes
        check("cfg_ready before offer", {31'd0, cfg_ready}, 32'd1);
        offer(10, 3);
        expect_cycles(1, 4, 2, 1);
        check("cfg_ready pending", {31'd0, cfg_ready}, 32'd0);
        // Second offer while pending must wait until the shadow is applied
        offer(6, 0);
        expect_cycles(2, 4, 2, 2);
        check("cfg_ready still pending", {31'd0, cfg_ready}, 32'd0);
        expect_cycles(1, 10, 3, 0);
        check("cfg_ready after apply", {31'd0, cfg_ready}, 32'd1);
        expect_cycles(1, 10, 3, 1);
        check("second cfg accepted", {31'd0, cfg_ready}, 32'd0);
        cfg_valid = 1'b0;
        expect_cycles(8, 10, 3, 2);
        // (6,0): ctrl stays low, cycle_start still every 6 cycles
        expect_cycles(12, 6, 0, 0);
        check("cfg_ready idle shadow", {31'd0, cfg_ready}, 32'd1);

        // Offer (1,5) in the wrap cycle: clamped to (2,2), applied one period later
        offer(1, 5);
        expect_cycles(1, 6, 0, 0);
        cfg_valid = 1'b0;
        check("cfg_ready wrap accept", {31'd0, cfg_ready}, 32'd0);
        expect_cycles(5, 6, 0, 1);
        expect_cycles(6, 2, 2, 0);
        check("cfg_ready after clamp apply", {31'd0, cfg_ready}, 32'd1);

        // Back to period 10 (high 4), then drop en at cnt=1
        offer(10, 4);
        expect_cycles(1, 2, 2, 0);
        cfg_valid = 1'b0;
        expect_cycles(1, 2, 2, 1);
        expect_cycles(2, 10, 4, 0);
        en = 1'b0;
        expect_cycles(8, 10, 4, 2);
        step();
        $display("[TB] after en drop: running=%0b ctrl=%0b", running, ctrl);
        check("idle running",     {31'd0, running},     32'd0);
        check("idle ctrl",        {31'd0, ctrl},        32'd0);
        check("idle cycle_start", {31'd0, cycle_start}, 32'd0);
        step();
        check("idle ctrl hold", {31'd0, ctrl}, 32'd0);

        // Restart with 10/4, park a pending config, then async reset at cnt=1
        en = 1'b1;
        expect_cycles(1, 10, 4, 0);
        offer(8, 8);
        expect_cycles(1, 10, 4, 1);
        cfg_valid = 1'b0;
        check("cfg_ready before reset", {31'd0, cfg_ready}, 32'd0);
        #2;
        emu_rst_n = 1'b0;
        #1;
        $display("[TB] async reset: ctrl=%0b running=%0b cfg_ready=%0b", ctrl, running, cfg_ready);
        check("async rst ctrl",      {31'd0, ctrl},      32'd0);
        check("async rst running",   {31'd0, running},   32'd0);
        check("async rst cfg_ready", {31'd0, cfg_ready}, 32'd1);
        step();
        emu_rst_n = 1'b1;
        // Defaults restored and the parked (8,8) config discarded
        expect_cycles(8, 4, 2, 0);
        check("cfg_ready after reset", {31'd0, cfg_ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
        $finish;
    end

endmodule
